// File: rtl/pipe_stage_reg.sv
// Pipeline-boundary register for the five-stage MIPS datapath: DEPTH stages of
// valid/ctrl/data with stall, flush (bubble insertion) and saturating perf counters.
module pipe_stage_reg #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8,
  parameter int DEPTH  = 1,
  parameter int CNT_W  = 16
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              In_Valid,
  input  logic [CTRL_W-1:0] In_Ctrl,
  input  logic [DATA_W-1:0] In_Data,
  input  logic              Stall,
  input  logic              Flush,
  input  logic              Clr_Cnt,
  output logic              Out_Valid,
  output logic [CTRL_W-1:0] Out_Ctrl,
  output logic [DATA_W-1:0] Out_Data,
  output logic [CNT_W-1:0]  Stall_Cnt,
  output logic [CNT_W-1:0]  Bubble_Cnt
);

  localparam int LAST = DEPTH - 1;

  generate
    if (DEPTH < 1 || DEPTH > 4) begin : g_bad_depth
      $error("pipe_stage_reg: DEPTH must be in the range 1..4");
    end
  endgenerate

  logic              valid_q [DEPTH];
  logic [CTRL_W-1:0] ctrl_q  [DEPTH];
  logic [DATA_W-1:0] data_q  [DEPTH];
  logic [CNT_W-1:0]  stall_cnt_q;
  logic [CNT_W-1:0]  bubble_cnt_q;

  // NOTE: sequential state uses non-blocking assignments so every stage samples
  // the pre-edge value of its predecessor, regardless of statement order.
  // NOTE: every stage array element is reset, because reset must force the
  // outputs to zero immediately; a non-reset payload would leak through Out_Data.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        valid_q[k] <= 1'b0;
        ctrl_q[k]  <= '0;
        data_q[k]  <= '0;
      end
    end else if (Flush) begin
      // Squash control only; data is held so a flushed slot carries no new value.
      for (int k = 0; k < DEPTH; k++) begin
        valid_q[k] <= 1'b0;
        ctrl_q[k]  <= '0;
      end
    end else if (!Stall) begin
      valid_q[0] <= In_Valid;
      ctrl_q[0]  <= In_Valid ? In_Ctrl : '0;
      data_q[0]  <= In_Data;
      for (int k = 1; k < DEPTH; k++) begin
        valid_q[k] <= valid_q[k-1];
        ctrl_q[k]  <= ctrl_q[k-1];
        data_q[k]  <= data_q[k-1];
      end
    end
  end

  // Counters saturate at all-ones; Clr_Cnt wins over any increment.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else if (Clr_Cnt) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      if (Stall && !Flush && (stall_cnt_q != {CNT_W{1'b1}})) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (!valid_q[LAST] && (bubble_cnt_q != {CNT_W{1'b1}})) begin
        bubble_cnt_q <= bubble_cnt_q + CNT_W'(1);
      end
    end
  end

  // Invalid stages always hold ctrl=0, so Out_Ctrl needs no gating here.
  assign Out_Valid  = valid_q[LAST];
  assign Out_Ctrl   = ctrl_q[LAST];
  assign Out_Data   = data_q[LAST];
  assign Stall_Cnt  = stall_cnt_q;
  assign Bubble_Cnt = bubble_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: a DEPTH=1/CNT_W=4 instance and a
// DEPTH=3/CNT_W=16 instance share one stimulus stream.
module tb_pipe_stage_reg;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        In_Valid;
  logic [7:0]  In_Ctrl;
  logic [31:0] In_Data;
  logic        Stall;
  logic        Flush;
  logic        Clr_Cnt;

  logic        a_valid, b_valid;
  logic [7:0]  a_ctrl, b_ctrl;
  logic [31:0] a_data, b_data;
  logic [3:0]  a_scnt, a_bcnt;
  logic [15:0] b_scnt, b_bcnt;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  pipe_stage_reg #(.DATA_W(32), .CTRL_W(8), .DEPTH(1), .CNT_W(4)) u_d1 (
    .Clk(Clk), .Rst_n(Rst_n), .In_Valid(In_Valid), .In_Ctrl(In_Ctrl),
    .In_Data(In_Data), .Stall(Stall), .Flush(Flush), .Clr_Cnt(Clr_Cnt),
    .Out_Valid(a_valid), .Out_Ctrl(a_ctrl), .Out_Data(a_data),
    .Stall_Cnt(a_scnt), .Bubble_Cnt(a_bcnt)
  );

  pipe_stage_reg #(.DATA_W(32), .CTRL_W(8), .DEPTH(3), .CNT_W(16)) u_d3 (
    .Clk(Clk), .Rst_n(Rst_n), .In_Valid(In_Valid), .In_Ctrl(In_Ctrl),
    .In_Data(In_Data), .Stall(Stall), .Flush(Flush), .Clr_Cnt(Clr_Cnt),
    .Out_Valid(b_valid), .Out_Ctrl(b_ctrl), .Out_Data(b_data),
    .Stall_Cnt(b_scnt), .Bubble_Cnt(b_bcnt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " d1 valid"}, 64'(a_valid), 64'd0);
    check({tag, " d1 ctrl"},  64'(a_ctrl),  64'd0);
    check({tag, " d1 data"},  64'(a_data),  64'd0);
    check({tag, " d1 scnt"},  64'(a_scnt),  64'd0);
    check({tag, " d1 bcnt"},  64'(a_bcnt),  64'd0);
    check({tag, " d3 valid"}, 64'(b_valid), 64'd0);
    check({tag, " d3 ctrl"},  64'(b_ctrl),  64'd0);
    check({tag, " d3 data"},  64'(b_data),  64'd0);
    check({tag, " d3 scnt"},  64'(b_scnt),  64'd0);
    check({tag, " d3 bcnt"},  64'(b_bcnt),  64'd0);
  endtask

  task automatic do_reset();
    Rst_n = 1'b0;
    #2;
    Rst_n = 1'b1;
  endtask

  initial begin
    Rst_n = 1'b0; Stall = 1'b0; Flush = 1'b0; Clr_Cnt = 1'b0;
    In_Valid = 1'b1; In_Ctrl = 8'h3C; In_Data = 32'h1234_5678;

    // Reset held while inputs toggle randomly.
    for (int i = 0; i < 3; i++) begin
      In_Valid = 1'($urandom); In_Ctrl = 8'($urandom); In_Data = $urandom;
      Stall = 1'($urandom); Clr_Cnt = 1'($urandom);
      step();
      check_all_zero("reset");
    end

    // First edge after release is a normal advance.
    Rst_n = 1'b1; Stall = 1'b0; Flush = 1'b0; Clr_Cnt = 1'b0;
    In_Valid = 1'b1; In_Ctrl = 8'hA5; In_Data = 32'hDEAD_BEEF;
    step();
    check("first d1 valid", 64'(a_valid), 64'd1);
    check("first d1 ctrl",  64'(a_ctrl),  64'hA5);
    check("first d1 data",  64'(a_data),  64'hDEAD_BEEF);
    check("first d1 bcnt",  64'(a_bcnt),  64'd1);
    check("first d1 scnt",  64'(a_scnt),  64'd0);

    // Latency on DEPTH=3: input k at edge k appears after edge k+2.
    do_reset();
    for (int k = 1; k <= 18; k++) begin
      In_Valid = 1'b1; In_Ctrl = 8'hFF; In_Data = 32'(k);
      step();
      check($sformatf("lat%0d valid", k), 64'(b_valid), (k >= 3) ? 64'd1 : 64'd0);
      check($sformatf("lat%0d ctrl", k),  64'(b_ctrl),  (k >= 3) ? 64'hFF : 64'd0);
      check($sformatf("lat%0d data", k),  64'(b_data),  (k >= 3) ? 64'(k - 2) : 64'd0);
      if (k >= 3) check($sformatf("lat%0d bcnt", k), 64'(b_bcnt), 64'd3);
    end

    // Stall 4 cycles with 0x10 at the output while In_Data changes.
    for (int i = 0; i < 4; i++) begin
      Stall = 1'b1; In_Data = 32'h55 + 32'(i);
      step();
      check($sformatf("stall%0d data", i),  64'(b_data),  64'h10);
      check($sformatf("stall%0d valid", i), 64'(b_valid), 64'd1);
    end
    check("stall d3 scnt", 64'(b_scnt), 64'd4);
    check("stall d1 data", 64'(a_data), 64'd18);
    Stall = 1'b0; In_Data = 32'd19;
    step();
    check("unstall data", 64'(b_data), 64'h11);
    check("unstall scnt", 64'(b_scnt), 64'd4);

    // Flush wins over Stall; data held, Stall_Cnt unchanged.
    Flush = 1'b1; Stall = 1'b1; In_Data = 32'h99;
    step();
    check("flush d3 valid", 64'(b_valid), 64'd0);
    check("flush d3 ctrl",  64'(b_ctrl),  64'd0);
    check("flush d3 data",  64'(b_data),  64'h11);
    check("flush d3 scnt",  64'(b_scnt),  64'd4);
    check("flush d1 valid", 64'(a_valid), 64'd0);
    check("flush d1 data",  64'(a_data),  64'd19);
    check("flush d1 scnt",  64'(a_scnt),  64'd4);

    // Bubbles with nonzero In_Ctrl must arrive with ctrl=0.
    Flush = 1'b0; Stall = 1'b0; In_Valid = 1'b0; In_Ctrl = 8'hFF; In_Data = 32'h77;
    step();
    check("bub d1 valid", 64'(a_valid), 64'd0);
    check("bub d1 ctrl",  64'(a_ctrl),  64'd0);
    check("bub d1 data",  64'(a_data),  64'h77);
    step();
    step();
    check("bub d3 valid", 64'(b_valid), 64'd0);
    check("bub d3 ctrl",  64'(b_ctrl),  64'd0);
    check("bub d3 data",  64'(b_data),  64'h77);

    // Saturation on CNT_W=4, then Clr_Cnt with Stall held.
    do_reset();
    In_Valid = 1'b1; In_Ctrl = 8'h0F; In_Data = 32'hCAFE;
    Stall = 1'b1;
    for (int i = 0; i < 20; i++) step();
    check("sat d1 scnt", 64'(a_scnt), 64'd15);
    check("sat d1 bcnt", 64'(a_bcnt), 64'd15);
    check("sat d3 scnt", 64'(b_scnt), 64'd20);
    Clr_Cnt = 1'b1;
    step();
    check("clr d1 scnt",  64'(a_scnt),  64'd0);
    check("clr d1 bcnt",  64'(a_bcnt),  64'd0);
    check("clr d3 scnt",  64'(b_scnt),  64'd0);
    check("clr d1 valid", 64'(a_valid), 64'd0);
    Clr_Cnt = 1'b0;
    step();
    check("post clr d1 scnt", 64'(a_scnt), 64'd1);
    check("post clr d1 bcnt", 64'(a_bcnt), 64'd1);

    // Asynchronous reset in the middle of a cycle.
    Stall = 1'b0; In_Valid = 1'b1; In_Ctrl = 8'h5A; In_Data = 32'hAB;
    step();
    step();
    step();
    check("pre rst d3 valid", 64'(b_valid), 64'd1);
    check("pre rst d3 data",  64'(b_data),  64'hAB);
    #2;
    Rst_n = 1'b0;
    #1;
    check_all_zero("async rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
